fp_addsub_seq: RTL and testbench
================================

Name: fp_addsub_seq

Overview:
- Multi-cycle, parametrised IEEE-754-style floating-point adder/subtractor.
- Successor to the combinational single-precision adder in the arithmetic chip.
- Adds over it: configurable exponent/mantissa widths, an add/sub mode input, hidden-bit handling, and a start/done handshake.
- Normalisation is a per-cycle shift FSM rather than an unrolled loop. Sits beside the multipliers under the same top-level operand bus.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width (hidden bit excluded); word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- sub  in  1  0: in1+in2, 1: in1-in2 (in2 sign inverted at capture).
- in1  in  W  operand A, captured on accepted start.
- in2  in  W  operand B, captured on accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, out/flags valid.
- out  out  W  result, held until next done.
- overFlow  out  1  result exponent saturated, held with out.
- zero  out  1  result is exactly zero, held with out.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, overFlow, zero = 0; out = 0; in-flight operation discarded.
- Handshake:
  - start accepted on an edge where busy=0 (IDLE, or the done cycle); busy rises on that edge.
  - start while busy=1 is ignored.
  - done high exactly one cycle; busy low in that same cycle, so back-to-back starts are allowed.
- Datapath: internal mantissa = hidden bit + MAN_W + 3 guard/round/sticky bits, plus 1 carry bit.
- Exponent-0 operands are flushed to signed zero (no denormals).
- FSM states: IDLE -> ALIGN -> ADD -> NORM -> IDLE, with done asserted on the NORM exit cycle.
  - ALIGN (edge 1):
    - Swap so |A| >= |B|, compared on exponent then mantissa.
    - Right-shift B by the exponent difference in one cycle; bits shifted out OR into sticky; difference >= MAN_W+4 makes B sticky-only.
    - If either exponent is all-ones: out = {0, all-ones, 1, zeros} (quiet NaN), overFlow=0, go straight to done at edge 2.
  - ADD (edge 2):
    - Same effective sign: add. On carry-out, shift right 1 (sticky-OR) and exponent+1.
    - Opposite effective sign: subtract magnitudes.
    - Result mantissa 0: out = +0 (sign 0), zero=1, done at edge 3.
  - NORM:
    - While hidden bit = 0 and exponent > 1: shift left 1, exponent-1, one per cycle.
    - If the exponent would reach 0, flush to signed zero with zero=1.
  - Exit: round, then pack. done at edge 3+k, where k = number of left shifts (0..MAN_W+3).
- Rounding (default): truncate; GRS discarded.
- Overflow: exponent reaching all-ones (after carry or rounding) gives out = {sign, all-ones, 0} and overFlow=1.
- Result sign = sign of larger-magnitude operand after sub inversion; exact zero is always +0.
- Outputs change only on done cycles (or reset).

Optional Feature:
- Macro: FPU_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even at NORM exit using guard/round/sticky.
  - Increment when G&(R|S|LSB).
  - Mantissa rollover renormalises in the same cycle with exponent+1; may raise overFlow.
  - Latency unchanged.
- Undefined: truncation; GRS logic may be removed.

Test Plan:
- Carry path: in1=0x3F800000, in2=0x3F800000, sub=0 -> out=0x40000000, done at edge 3, overFlow=0, zero=0.
- Cancellation with normalise: in1=0x3F800000, in2=0xBF400000, sub=0 -> out=0x3E800000, k=2, done at edge 5; same result with in2=0x3F400000, sub=1.
- Exact zero: in1=in2=0x40490FDB, sub=1 -> out=0x00000000, zero=1, done at edge 3.
- Overflow: in1=in2=0x7F7FFFFF, sub=0 -> out=0x7F800000, overFlow=1.
- Rounding: in1=0x3F800000, in2=0x33C00000 -> 0x3F800000 without FPU_ROUND_NEAREST_EN, 0x3F800001 with it.
- Handshake/reset:
  - start held high continuously: second operation accepted on the done cycle, with no idle gap.
  - start pulsed during busy: ignored.
  - rst_n low during NORM: busy, done, out cleared immediately; no done pulse follows.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle parametrised floating-point adder/subtractor (IDLE/ALIGN/ADD/NORM).
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even at pack; the default build truncates.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [EXP_W+MAN_W:0] in1,
    input  logic [EXP_W+MAN_W:0] in2,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] out,
    output logic                 overFlow,
    output logic                 zero
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;   // hidden + mantissa + guard/round/sticky
    localparam int SW = MW + 1;      // plus carry
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM} state_t;

    state_t         state_q;
    logic           busy_q, done_q, ovf_q, zero_q;
    logic [W-1:0]   out_q;

    logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [SW-1:0]    ma_q, ma_d, mb_q, mb_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sign_q, sign_d, eff_sub_q, eff_sub_d;
    logic             nan_q, nan_d, zres_q, zres_d;

    logic [W-2:0]     mag_a, mag_b, mag_big, mag_sml;
    logic             swap, sgn_big, nan_in;
    logic [EXP_W-1:0] e_big, e_sml, exp_add;
    logic [MW-1:0]    m_big, m_sml, m_shf;
    logic [SW-1:0]    sum, sum_n;
    logic             norm_exit, res_ovf, res_zero;
    logic [W-1:0]     res_word;
    logic [W:0]       pack_res;

    // Right shift by d; every bit pushed off the end is ORed into the sticky position.
    function automatic logic [MW-1:0] align_shift(input logic [MW-1:0] m, input logic [EXP_W-1:0] d);
        logic [MW-1:0] lost_mask;
        logic [MW-1:0] r;
        lost_mask = '0;
        if (32'(d) >= MW) begin
            r    = '0;
            r[0] = |m;
        end else begin
            lost_mask = ~({MW{1'b1}} << d);
            r         = m >> d;
            r[0]      = r[0] | (|(m & lost_mask));
        end
        return r;
    endfunction

`ifdef FPU_ROUND_NEAREST_EN
    // Returns {overflow, word}; mantissa rollover bumps the exponent in the same cycle.
    function automatic logic [W:0] round_pack(input logic s, input logic [EXP_W-1:0] e,
                                              input logic [MW-1:0] m);
        logic [MAN_W+1:0] rnd;
        logic [EXP_W-1:0] e_r;
        logic             inc;
        inc = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        e_r = e;
        if (rnd[MAN_W+1] && (e != EXP_ONES))
            e_r = e + EXP_W'(1);
        if (e_r == EXP_ONES)
            return {1'b1, s, EXP_ONES, {MAN_W{1'b0}}};
        return {1'b0, s, e_r, rnd[MAN_W-1:0]};
    endfunction

    assign pack_res = round_pack(sign_q, exp_q, ma_q[MW-1:0]);
`else
    function automatic logic [W:0] round_pack(input logic s, input logic [EXP_W-1:0] e,
                                              input logic [MAN_W-1:0] f);
        if (e == EXP_ONES)
            return {1'b1, s, EXP_ONES, {MAN_W{1'b0}}};
        return {1'b0, s, e, f};
    endfunction

    assign pack_res = round_pack(sign_q, exp_q, ma_q[MW-2:3]);
`endif

    // Flush exponent-0 operands, order by magnitude, align the smaller one.
    always_comb begin
        mag_a   = (opa_q[W-2:MAN_W] == '0) ? '0 : opa_q[W-2:0];
        mag_b   = (opb_q[W-2:MAN_W] == '0) ? '0 : opb_q[W-2:0];
        swap    = mag_b > mag_a;
        mag_big = swap ? mag_b : mag_a;
        mag_sml = swap ? mag_a : mag_b;
        sgn_big = swap ? opb_q[W-1] : opa_q[W-1];
        nan_in  = (opa_q[W-2:MAN_W] == EXP_ONES) || (opb_q[W-2:MAN_W] == EXP_ONES);
        e_big   = mag_big[W-2:MAN_W];
        e_sml   = mag_sml[W-2:MAN_W];
        m_big   = {(e_big != '0), mag_big[MAN_W-1:0], 3'b000};
        m_sml   = {(e_sml != '0), mag_sml[MAN_W-1:0], 3'b000};
        m_shf   = align_shift(m_sml, e_big - e_sml);
    end

    always_comb begin
        sum     = eff_sub_q ? (ma_q - mb_q) : (ma_q + mb_q);
        sum_n   = sum;
        exp_add = exp_q;
        if (sum[SW-1]) begin
            sum_n    = {1'b0, sum[SW-1:1]};
            sum_n[0] = sum[1] | sum[0];
            exp_add  = exp_q + EXP_W'(1);
        end
    end

    // Exponent 1 with no hidden bit cannot shift further: that is the underflow flush.
    always_comb begin
        norm_exit = zres_q || ma_q[MW-1] || (exp_q <= EXP_W'(1));
        res_word  = '0;
        res_ovf   = 1'b0;
        res_zero  = 1'b1;
        if (!zres_q && !ma_q[MW-1]) begin
            res_word = {sign_q, {(W-1){1'b0}}};
        end else if (!zres_q) begin
            {res_ovf, res_word} = pack_res;
            res_zero            = 1'b0;
        end
    end

    always_comb begin
        opa_d     = opa_q;
        opb_d     = opb_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        nan_d     = nan_q;
        zres_d    = zres_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d = in1;
                    opb_d = {in2[W-1] ^ sub, in2[W-2:0]};
                end
            end
            S_ALIGN: begin
                ma_d      = {1'b0, m_big};
                mb_d      = {1'b0, m_shf};
                exp_d     = e_big;
                sign_d    = sgn_big;
                eff_sub_d = opa_q[W-1] ^ opb_q[W-1];
                nan_d     = nan_in;
            end
            S_ADD: begin
                ma_d   = sum_n;
                exp_d  = exp_add;
                zres_d = (sum == '0);
            end
            S_NORM: begin
                if (!norm_exit) begin
                    ma_d  = ma_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        opa_q     <= opa_d;
        opb_q     <= opb_d;
        ma_q      <= ma_d;
        mb_q      <= mb_d;
        exp_q     <= exp_d;
        sign_q    <= sign_d;
        eff_sub_q <= eff_sub_d;
        nan_q     <= nan_d;
        zres_q    <= zres_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ALIGN;
                        busy_q  <= 1'b1;
                    end
                end
                S_ALIGN: state_q <= S_ADD;
                S_ADD: begin
                    if (nan_q) begin
                        out_q   <= QNAN;
                        ovf_q   <= 1'b0;
                        zero_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (norm_exit) begin
                        out_q   <= res_word;
                        ovf_q   <= res_ovf;
                        zero_q  <= res_zero;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign out      = out_q;
    assign overFlow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (single precision) with a scoreboard of expected results.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        busy, done, overFlow, zero;
    logic [31:0] out;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        zr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

`ifdef FPU_ROUND_NEAREST_EN
    localparam logic [31:0] RND_EXP = 32'h3F800001;
`else
    localparam logic [31:0] RND_EXP = 32'h3F800000;
`endif

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .in1(in1), .in2(in2), .busy(busy), .done(done),
        .out(out), .overFlow(overFlow), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts edges after the accept edge; base is how many have already passed.
    task automatic wait_done(input string tag, input int base, output int lat);
        lat = -1;
        for (int n = base + 1; n <= base + 60; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk({tag, " done_timeout"}, {63'd0, done}, 64'd1);
    endtask

    task automatic check_result(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty at done", tag);
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        chk({tag, " lat"}, 64'(lat), 64'(e.lat));
        chk({tag, " out"}, {32'd0, out}, {32'd0, e.res});
        chk({tag, " ovf"}, {63'd0, overFlow}, {63'd0, e.ovf});
        chk({tag, " zero"}, {63'd0, zero}, {63'd0, e.zr});
        chk({tag, " busy_low"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eo, input logic eov, input logic ez, input int el);
        int lat;
        sb.push_back('{eo, eov, ez, el});
        in1 = a;
        in2 = b;
        sub = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy_rise"}, {63'd0, busy}, 64'd1);
        wait_done(tag, 0, lat);
        check_result(tag, lat);
        tick();
        chk({tag, " done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, " out_held"}, {32'd0, out}, {32'd0, eo});
    endtask

    initial begin
        int lat;
        logic seen;

        tick();
        tick();
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst done", {63'd0, done}, 64'd0);
        chk("rst out", {32'd0, out}, 64'd0);
        chk("rst ovf", {63'd0, overFlow}, 64'd0);
        chk("rst zero", {63'd0, zero}, 64'd0);
        rst_n = 1'b1;
        tick();

        do_op("carry",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 3);
        do_op("cancel",    32'h3F800000, 32'hBF400000, 1'b0, 32'h3E800000, 1'b0, 1'b0, 5);
        do_op("cancel_sb", 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 5);
        do_op("exactzero", 32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 1'b0, 1'b1, 3);
        do_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3);
        do_op("round",     32'h3F800000, 32'h33C00000, 1'b0, RND_EXP,      1'b0, 1'b0, 3);
        do_op("nan",       32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 2);
        do_op("denorm",    32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3);
        do_op("negres",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 4);
        do_op("longnorm",  32'h3F800000, 32'hBF7FFFFF, 1'b0, 32'h33800000, 1'b0, 1'b0, 27);
        do_op("underflow", 32'h80800001, 32'h00800000, 1'b0, 32'h80000000, 1'b0, 1'b1, 3);

        // start held high: the second operation is taken on the done cycle.
        sb.push_back('{32'h40000000, 1'b0, 1'b0, 3});
        sb.push_back('{32'h40800000, 1'b0, 1'b0, 3});
        in1 = 32'h3F800000;
        in2 = 32'h3F800000;
        sub = 1'b0;
        start = 1'b1;
        tick();
        in1 = 32'h40000000;
        in2 = 32'h40000000;
        wait_done("b2b1", 0, lat);
        check_result("b2b1", lat);
        tick();
        start = 1'b0;
        chk("b2b accept_busy", {63'd0, busy}, 64'd1);
        chk("b2b done_pulse", {63'd0, done}, 64'd0);
        wait_done("b2b2", 0, lat);
        check_result("b2b2", lat);
        tick();

        // start pulsed while busy must not disturb the running operation or queue another.
        sb.push_back('{32'h40000000, 1'b0, 1'b0, 3});
        in1 = 32'h3F800000;
        in2 = 32'h3F800000;
        sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in1 = 32'h7F800000;
        in2 = 32'h12345678;
        sub = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignored", 2, lat);
        check_result("ignored", lat);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("ignored no_extra_op", {63'd0, seen}, 64'd0);

        // Reset in the middle of the long normalisation: outputs clear at once, no done follows.
        in1 = 32'h3F800000;
        in2 = 32'hBF7FFFFF;
        sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst done", {63'd0, done}, 64'd0);
        chk("midrst out", {32'd0, out}, 64'd0);
        chk("midrst ovf", {63'd0, overFlow}, 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("postrst no_done", {63'd0, seen}, 64'd0);
        chk("postrst out", {32'd0, out}, 64'd0);

        do_op("after_rst", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0, 3);
        chk("sb drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
